// File: rtl/run_ctrl_if.sv
// Purpose : bundles the host load/drain streams, core control and data-memory
//           port of the run sequencer into one interface.
// Ports   : master = sequencer side (drives core/memory/host outputs),
//           slave  = environment side (host, core and data memory).
interface run_ctrl_if #(
    parameter int AW = 8,
    parameter int CW = 16
);
    // host control and status
    logic          req;
    logic          busy;
    logic          ack;
    logic          timeout;
    logic [CW-1:0] cycle_cnt;

    // load stream (host -> data memory)
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_ready;

    // result stream (data memory -> host)
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          rd_ready;

    // core control
    logic          core_reset;
    logic          core_done;

    // data-memory port
    logic          mem_sel;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dat;
    logic [7:0]    mem_rd_dat;

    modport master (
        input  req, ld_valid, ld_data, rd_ready, core_done, mem_rd_dat,
        output busy, ack, timeout, cycle_cnt, ld_ready, rd_valid, rd_data,
               core_reset, mem_sel, mem_wr_en, mem_addr, mem_dat
    );

    modport slave (
        output req, ld_valid, ld_data, rd_ready, core_done, mem_rd_dat,
        input  busy, ack, timeout, cycle_cnt, ld_ready, rd_valid, rd_data,
               core_reset, mem_sel, mem_wr_en, mem_addr, mem_dat
    );
endinterface

// File: rtl/run_ctrl.sv
// Purpose : host-side sequencer for the processor core: loads a test vector into
//           data memory with the core held in reset, releases and times the core
//           until done (or timeout), then freezes it and streams a result window out.
// Latency : load byte written in its handshake cycle; result byte presented
//           combinationally from memory the same cycle its address is driven.
// Backpr. : ld_valid/ld_ready and rd_valid/rd_ready; a stalled stream holds the
//           pointer, so address and data stay frozen until the handshake.
// Ports   : clk, reset (sync, active-high), bus (run_ctrl_if.master: req/busy/
//           ack/timeout/cycle_cnt, ld_*, rd_*, core_reset/core_done, mem_*).
module run_ctrl #(
    parameter int AW      = 8,
    parameter int LD_BASE = 0,
    parameter int LD_LEN  = 64,
    parameter int RD_BASE = 64,
    parameter int RD_LEN  = 32,
    parameter int CW      = 16,
    parameter int TIMEOUT = 20000
) (
    input  logic         clk,
    input  logic         reset,
    run_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

    // The byte counter is shared by load and drain, so size it for the longer.
    localparam int LEN_MAX = (LD_LEN > RD_LEN) ? LD_LEN : RD_LEN;
    localparam int NW      = $clog2(LEN_MAX) + 1;

    state_t        state;
    state_t        state_nxt;

    logic [AW-1:0] ptr;
    logic [NW-1:0] cnt;
    logic [CW-1:0] cyc;
    logic          to_q;

    logic          ld_hs;
    logic          ld_last;
    logic          rd_hs;
    logic          rd_last;
    logic          run_term;

    // A load handshake is suppressed while reset is asserted so that an abort
    // in the middle of a load never lets one more byte into memory.
    assign ld_hs    = (state == LOAD) && bus.ld_valid && !reset;
    assign ld_last  = (cnt == NW'(LD_LEN - 1));
    assign rd_hs    = (state == DRAIN) && bus.rd_ready;
    assign rd_last  = (cnt == NW'(RD_LEN - 1));
    assign run_term = (cyc == CW'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (ld_hs && ld_last) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Done and the timeout terminal count both leave for DRAIN;
                // which of them set the timeout flag is sorted out below.
                if (bus.core_done || run_term) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_hs && rd_last) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address pointer, byte counter, run timer, timeout flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr  <= '0;
            cnt  <= '0;
            cyc  <= '0;
            to_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        ptr  <= AW'(LD_BASE);
                        cnt  <= '0;
                        cyc  <= '0;
                        to_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (ld_hs) begin
                        ptr <= ptr + AW'(1);
                        cnt <= cnt + NW'(1);
                    end
                end
                RUN: begin
                    // The cycle in which done is seen still counts as a run cycle.
                    cyc <= cyc + CW'(1);
                    if (bus.core_done || run_term) begin
                        ptr <= AW'(RD_BASE);
                        cnt <= '0;
                    end
                    // Done has priority: a simultaneous terminal count is not a timeout.
                    if (!bus.core_done && run_term) begin
                        to_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (rd_hs) begin
                        ptr <= ptr + AW'(1);
                        cnt <= cnt + NW'(1);
                    end
                end
                default: begin
                    // FINISH: cycle count and timeout flag hold for the host.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        bus.core_reset = 1'b1;
        bus.mem_sel    = 1'b1;
        bus.ld_ready   = 1'b0;
        bus.mem_wr_en  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_dat    = '0;
        bus.rd_valid   = 1'b0;
        bus.rd_data    = '0;
        bus.busy       = (state != IDLE);
        bus.ack        = 1'b0;
        case (state)
            LOAD: begin
                bus.ld_ready  = !reset;
                bus.mem_wr_en = ld_hs;
                bus.mem_addr  = ptr;
                bus.mem_dat   = bus.ld_data;
            end
            RUN: begin
                // Core owns the memory port and runs out of reset.
                bus.core_reset = 1'b0;
                bus.mem_sel    = 1'b0;
            end
            DRAIN: begin
                bus.mem_addr = ptr;
                bus.rd_valid = 1'b1;
                bus.rd_data  = bus.mem_rd_dat;
            end
            FINISH: begin
                bus.ack = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.cycle_cnt = cyc;
    assign bus.timeout   = to_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Purpose : directed scoreboard bench for run_ctrl; models the data memory and a
//           core that raises done a programmable number of cycles after release.
// Ports   : none (top-level bench); drives the DUT through a run_ctrl_if instance.
module tb_run_ctrl;
    localparam int AW  = 8;
    localparam int CW  = 16;
    localparam int TMO = 120;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    run_ctrl_if #(.AW(AW), .CW(CW)) bus ();

    run_ctrl #(
        .AW(AW), .LD_BASE(0), .LD_LEN(64), .RD_BASE(64), .RD_LEN(32),
        .CW(CW), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- data memory model ----------------
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'(a) ^ 8'h5A;
        end else if (bus.mem_sel && bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_dat;
        end
    end
    assign bus.mem_rd_dat = mem[bus.mem_addr];

    // ---------------- core model ----------------
    int rc      = 0;
    int done_at = 0;   // 0 = never raise done
    always @(posedge clk) begin
        if (bus.core_reset) rc <= 0;
        else                rc <= rc + 1;
    end
    assign bus.core_done = !bus.core_reset && (done_at != 0) && (rc == done_at - 1);

    // ---------------- scoreboard ----------------
    logic [15:0]   wq [$];   // {addr, data} of expected memory writes
    logic [7:0]    rq [$];   // expected result bytes
    logic [CW:0]   aq [$];   // {timeout, cycle_cnt} expected at each ack
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen/missed with nothing expected", name);
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    always @(negedge clk) begin
        if (bus.mem_wr_en === 1'b1) begin
            if (wq.size() == 0) fail("unexpected_write");
            else chk("mem_write", 64'({bus.mem_addr, bus.mem_dat}), 64'(wq.pop_front()));
        end
        if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
            if (rq.size() == 0) fail("unexpected_rd");
            else chk("rd_byte", 64'(bus.rd_data), 64'(rq.pop_front()));
        end
        if (bus.ack === 1'b1) begin
            if (aq.size() == 0) fail("unexpected_ack");
            else chk("ack_cnt_timeout", 64'({bus.timeout, bus.cycle_cnt}), 64'(aq.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit gap, input bit stall, input int dat0, input int dly,
                       input int exp_cnt, input bit exp_to, input bit req_busy);
        int n;
        logic [7:0] e3;
        done_at = dly;
        aq.push_back({exp_to, CW'(exp_cnt)});
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        chk("load_ready", 64'(bus.ld_ready), 64'(1));
        for (int i = 0; i < 64; i++) begin
            wq.push_back({8'(i), 8'(dat0 + i)});
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'(dat0 + i);
            if (i == 63) chk("core_reset_before_last", 64'(bus.core_reset), 64'(1));
            tick();
            if (i == 63) chk("core_released", 64'({bus.core_reset, bus.mem_sel}), 64'(0));
            if (gap) begin
                bus.ld_valid = 1'b0;
                bus.ld_data  = 8'hEE;
                tick();
            end
        end
        bus.ld_valid = 1'b0;
        n = 0;
        while (bus.rd_valid !== 1'b1 && n < 2000) begin
            if (req_busy && n == 5) bus.req = 1'b1;
            tick();
            bus.req = 1'b0;
            n++;
        end
        if (bus.rd_valid !== 1'b1) begin
            fail("drain_wait_timeout");
            finish_sim();
        end
        e3 = 8'd67 ^ 8'h5A;
        for (int i = 0; i < 32; i++) begin
            if (stall && i == 3) begin
                bus.rd_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_data", 64'(bus.rd_data), 64'(e3));
                    chk("stall_addr", 64'(bus.mem_addr), 64'(67));
                end
            end
            rq.push_back(8'(64 + i) ^ 8'h5A);
            bus.rd_ready = 1'b1;
            if (req_busy && i == 10) bus.req = 1'b1;
            tick();
            bus.req = 1'b0;
        end
        bus.rd_ready = 1'b0;
        chk("ack_pulse", 64'(bus.ack), 64'(1));
        tick();
        chk("ack_one_cycle_idle", 64'({bus.ack, bus.busy}), 64'(0));
        chk("result_hold", 64'({bus.timeout, bus.cycle_cnt}), 64'({exp_to, CW'(exp_cnt)}));
    endtask

    initial begin
        #200000;
        fail("watchdog");
        finish_sim();
    end

    initial begin
        reset        = 1'b1;
        bus.req      = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
        bus.rd_ready = 1'b0;
        repeat (3) tick();
        chk("reset_state",
            64'({bus.core_reset, bus.mem_sel, bus.ld_ready, bus.mem_wr_en, bus.rd_valid,
                 bus.busy, bus.ack, bus.timeout, bus.mem_addr, bus.mem_dat, bus.rd_data,
                 bus.cycle_cnt}),
            64'({1'b1, 1'b1, 6'b0, 8'h00, 8'h00, 8'h00, 16'h0000}));
        reset = 1'b0;
        tick();
        chk("idle_no_req", 64'(bus.busy), 64'(0));

        // load 0x00..0x3F, done 100 cycles after release
        run(1'b0, 1'b0, 8'h00, 100, 100, 1'b0, 1'b0);
        // toggling ld_valid and a 5-cycle rd stall on byte 3
        run(1'b1, 1'b1, 8'h40, 50, 50, 1'b0, 1'b0);
        // done never asserted: forced abort after TMO run cycles
        run(1'b0, 1'b0, 8'h80, 0, TMO, 1'b1, 1'b0);
        // done seen on the terminal run cycle: done wins
        run(1'b0, 1'b0, 8'h11, TMO, TMO, 1'b0, 1'b0);
        // req pulsed during RUN and DRAIN is ignored
        run(1'b0, 1'b0, 8'h22, 30, 30, 1'b0, 1'b1);

        // reset after 10 load bytes, ld_valid still high
        done_at = 0;
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wq.push_back({8'(i), 8'(8'h90 + i)});
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'(8'h90 + i);
            tick();
        end
        bus.ld_data = 8'hAA;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_idle",
            64'({bus.busy, bus.core_reset, bus.mem_sel, bus.ld_ready, bus.mem_wr_en}),
            64'(5'b01100));
        tick();
        chk("abort_no_restart", 64'(bus.busy), 64'(0));
        bus.ld_valid = 1'b0;
        // a following req restarts at LD_BASE
        run(1'b0, 1'b0, 8'h33, 10, 10, 1'b0, 1'b0);

        repeat (3) tick();
        chk("writes_all_seen", 64'(wq.size()), 64'(0));
        chk("reads_all_seen", 64'(rq.size()), 64'(0));
        chk("acks_all_seen", 64'(aq.size()), 64'(0));
        finish_sim();
    end
endmodule
